pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_seq_pkg.sv | 10 +
 rtl/ret_addr_stack.sv | 51 +++++
 rtl/pc_sequencer.sv | 134 +++++++++++++
 tb/tb_pc_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared state encoding and parameter defaults for the PC sequencer.
package pc_seq_pkg;
    localparam int              PC_W_DEF        = 16;
    localparam int              BR_IMM_W_DEF    = 6;
    localparam int              J_IMM_W_DEF     = 12;
    localparam int              STACK_DEPTH_DEF = 4;
    localparam logic [15:0]     INT_VECTOR_DEF  = 16'h0010;

    typedef enum logic {RUN = 1'b0, HALT = 1'b1} seq_state_e;
endpackage

// File: rtl/ret_addr_stack.sv
// Return-address LIFO; a push when full or a pop when empty is ignored.
module ret_addr_stack
    import pc_seq_pkg::*;
#(
    parameter int PC_W        = PC_W_DEF,
    parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] push_data,
    output logic [PC_W-1:0] top,
    output logic            empty,
    output logic            full
);
    localparam int CW = $clog2(STACK_DEPTH) + 1;

    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   top_idx;
    logic [PC_W-1:0] mem_q [STACK_DEPTH];
    logic            do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(STACK_DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty && !do_push;
    assign top_idx = count_q - CW'(1);
    assign top     = mem_q[top_idx[CW-2:0]];

    always_comb begin
        count_d = count_q;
        if (do_push)
            count_d = count_q + CW'(1);
        else if (do_pop)
            count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    // Entries need no reset: only the count decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push)
            mem_q[count_q[CW-2:0]] <= push_data;
    end
endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: branch/jump/call/return, halt/resume and a
// single vectored interrupt with a hardware return-address stack.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              PC_W        = PC_W_DEF,
    parameter int              BR_IMM_W    = BR_IMM_W_DEF,
    parameter int              J_IMM_W     = J_IMM_W_DEF,
    parameter int              STACK_DEPTH = STACK_DEPTH_DEF,
    parameter logic [PC_W-1:0] INT_VECTOR  = PC_W'(INT_VECTOR_DEF)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clk_en,
    input  logic                branch_taken,
    input  logic [BR_IMM_W-1:0] branch_imm,
    input  logic                jump_taken,
    input  logic                jump_link,
    input  logic [J_IMM_W-1:0]  jump_imm,
    input  logic                ret_cmd,
    input  logic                halt_cmd,
    input  logic                resume,
    input  logic                int_req,
    input  logic                int_enable_cmd,
    input  logic                int_disable_cmd,
    output logic [PC_W-1:0]     pc,
    output logic                halted,
    output logic                int_enabled,
    output logic                int_ack,
    output logic                stack_empty,
    output logic                stack_full,
    output logic                stack_overflow,
    output logic                stack_underflow
);
    seq_state_e      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, pc_inc, br_tgt, jmp_tgt, br_off, jmp_off, stk_top;
    logic            ien_q, ien_d, ack_q, ack_d, ovf_q, ovf_d, unf_q, unf_d;
    logic            push, pop, take_int;

    // Word offsets: sign-extend then scale to bytes.
    assign br_off  = {{(PC_W-BR_IMM_W){branch_imm[BR_IMM_W-1]}}, branch_imm};
    assign jmp_off = {{(PC_W-J_IMM_W){jump_imm[J_IMM_W-1]}}, jump_imm};
    assign pc_inc  = pc_q + PC_W'(2);
    assign br_tgt  = pc_q + {br_off[PC_W-2:0], 1'b0};
    assign jmp_tgt = pc_q + {jmp_off[PC_W-2:0], 1'b0};

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        push     = 1'b0;
        pop      = 1'b0;
        take_int = 1'b0;
        ack_d    = 1'b0;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (clk_en) begin
            if (state_q == RUN) begin
                if (halt_cmd) begin
                    state_d = HALT;
                end else if (int_req && ien_q) begin
                    take_int = 1'b1;
                    push     = 1'b1;
                    ack_d    = 1'b1;
                    pc_d     = INT_VECTOR;
                end else if (ret_cmd) begin
                    if (stack_empty) begin
                        unf_d = 1'b1;
                        pc_d  = pc_inc;
                    end else begin
                        pop  = 1'b1;
                        pc_d = stk_top;
                    end
                end else if (jump_taken) begin
                    push = jump_link;
                    pc_d = jmp_tgt;
                end else if (branch_taken) begin
                    pc_d = br_tgt;
                end else begin
                    pc_d = pc_inc;
                end
            end else if (resume) begin
                state_d = RUN;
                pc_d    = pc_inc;
            end
        end
        if (push && stack_full)
            ovf_d = 1'b1;
        // Enable/disable act even when stalled or halted; entry clear wins.
        ien_d = ien_q;
        if (int_enable_cmd)
            ien_d = 1'b1;
        if (int_disable_cmd || take_int)
            ien_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= '0;
            ien_q   <= 1'b0;
            ack_q   <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ien_q   <= ien_d;
            ack_q   <= ack_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    ret_addr_stack #(
        .PC_W       (PC_W),
        .STACK_DEPTH(STACK_DEPTH)
    ) u_stack (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .push_data(pc_inc),
        .top      (stk_top),
        .empty    (stack_empty),
        .full     (stack_full)
    );

    assign pc              = pc_q;
    assign halted          = (state_q == HALT);
    assign int_enabled     = ien_q;
    assign int_ack         = ack_q;
    assign stack_overflow  = ovf_q;
    assign stack_underflow = unf_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench: behavioural model feeds an expectation queue each cycle.
module tb_pc_sequencer;
    logic        clk = 1'b0, reset = 1'b1, clk_en;
    logic        branch_taken, jump_taken, jump_link, ret_cmd;
    logic        halt_cmd, resume, int_req, int_enable_cmd, int_disable_cmd;
    logic [5:0]  branch_imm;
    logic [11:0] jump_imm;
    logic [15:0] pc;
    logic        halted, int_enabled, int_ack, stack_empty, stack_full;
    logic        stack_overflow, stack_underflow;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .clk_en(clk_en),
        .branch_taken(branch_taken), .branch_imm(branch_imm),
        .jump_taken(jump_taken), .jump_link(jump_link), .jump_imm(jump_imm),
        .ret_cmd(ret_cmd), .halt_cmd(halt_cmd), .resume(resume),
        .int_req(int_req), .int_enable_cmd(int_enable_cmd),
        .int_disable_cmd(int_disable_cmd),
        .pc(pc), .halted(halted), .int_enabled(int_enabled), .int_ack(int_ack),
        .stack_empty(stack_empty), .stack_full(stack_full),
        .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [6:0]  fl;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0, errors = 0;
    logic [15:0] m_pc, m_stk[$];
    logic        m_halt, m_ien, m_ack, m_ovf, m_unf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] dut_flags();
        return {halted, int_enabled, int_ack, stack_empty, stack_full, stack_overflow, stack_underflow};
    endfunction

    function automatic logic [6:0] m_flags();
        return {m_halt, m_ien, m_ack, (m_stk.size() == 0), (m_stk.size() == 4), m_ovf, m_unf};
    endfunction

    task automatic m_reset();
        m_pc = 16'h0; m_halt = 0; m_ien = 0; m_ack = 0; m_ovf = 0; m_unf = 0;
        m_stk.delete();
    endtask

    task automatic m_push(input logic [15:0] a);
        if (m_stk.size() == 4) m_ovf = 1;
        else m_stk.push_back(a);
    endtask

    task automatic idle();
        clk_en = 1; branch_taken = 0; branch_imm = '0; jump_taken = 0; jump_link = 0;
        jump_imm = '0; ret_cmd = 0; halt_cmd = 0; resume = 0; int_req = 0;
        int_enable_cmd = 0; int_disable_cmd = 0;
    endtask

    // Model one clock from current inputs, queue the expectation, then compare.
    task automatic cycle(input string tag);
        logic [15:0] bo, jo;
        logic        ien_old;
        exp_t        e;
        bo = {{10{branch_imm[5]}}, branch_imm};
        jo = {{4{jump_imm[11]}}, jump_imm};
        ien_old = m_ien;
        m_ack = 0;
        if (int_enable_cmd) m_ien = 1;
        if (int_disable_cmd) m_ien = 0;
        if (clk_en) begin
            if (!m_halt) begin
                if (halt_cmd) m_halt = 1;
                else if (int_req && ien_old) begin
                    m_push(m_pc + 16'd2); m_pc = 16'h0010; m_ien = 0; m_ack = 1;
                end else if (ret_cmd) begin
                    if (m_stk.size() == 0) begin m_unf = 1; m_pc = m_pc + 16'd2; end
                    else m_pc = m_stk.pop_back();
                end else if (jump_taken) begin
                    if (jump_link) m_push(m_pc + 16'd2);
                    m_pc = m_pc + (jo << 1);
                end else if (branch_taken) m_pc = m_pc + (bo << 1);
                else m_pc = m_pc + 16'd2;
            end else if (resume) begin
                m_halt = 0; m_pc = m_pc + 16'd2;
            end
        end
        e.pc = m_pc; e.fl = m_flags();
        sb.push_back(e);
        @(posedge clk); #1;
        e = sb.pop_front();
        chk({tag, ".pc"}, 32'(pc), 32'(e.pc));
        chk({tag, ".fl"}, 32'(dut_flags()), 32'(e.fl));
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1; #1;
        m_reset(); sb.delete();
        @(negedge clk); reset = 0;
    endtask

    task automatic jump(input logic [11:0] imm, input logic link);
        idle(); jump_taken = 1; jump_link = link; jump_imm = imm;
        cycle("jmp"); idle();
    endtask

    initial begin
        idle(); m_reset();
        #12;
        chk("rst.pc", 32'(pc), 32'h0);
        chk("rst.fl", 32'(dut_flags()), 32'(7'b0001000));
        @(negedge clk); reset = 0;

        // Backward branch and maximal forward jump
        jump(12'd8, 0);
        chk("b.pc10", 32'(pc), 32'h0010);
        branch_taken = 1; branch_imm = 6'b111110; cycle("br"); idle();
        chk("b.neg", 32'(pc), 32'h000C);
        do_reset();
        jump(12'h7FF, 0);
        chk("j.max", 32'(pc), 32'h0FFE);

        // Call and return
        do_reset();
        jump(12'd16, 0);
        jump(12'd8, 1);
        chk("jl.pc", 32'(pc), 32'h0030);
        cycle("seq");
        clk_en = 0; jump_taken = 1; cycle("stall"); idle();
        ret_cmd = 1; cycle("ret"); idle();
        chk("ret.pc", 32'(pc), 32'h0022);
        chk("ret.empty", 32'(stack_empty), 32'h1);

        // Nested calls past the stack depth
        do_reset();
        for (int i = 0; i < 5; i++) jump(12'd16, 1);
        chk("ovf", 32'(stack_overflow), 32'h1);
        for (int i = 0; i < 4; i++) begin
            ret_cmd = 1; cycle("nret"); idle();
            chk("nret.pc", 32'(pc), 32'(16'h0062 - 16'(i * 32)));
        end
        ret_cmd = 1; cycle("uret"); idle();
        chk("unf", 32'(stack_underflow), 32'h1);
        chk("unf.pc", 32'(pc), 32'h0004);

        // Interrupt entry and return
        do_reset();
        int_enable_cmd = 1; cycle("ien"); idle();
        jump(12'd31, 0);
        chk("i.pc40", 32'(pc), 32'h0040);
        int_req = 1; int_enable_cmd = 1; cycle("int"); idle();
        chk("i.vec", 32'(pc), 32'h0010);
        chk("i.ack", 32'(int_ack), 32'h1);
        chk("i.ien", 32'(int_enabled), 32'h0);
        ret_cmd = 1; cycle("iret"); idle();
        chk("i.ack0", 32'(int_ack), 32'h0);
        chk("i.ret", 32'(pc), 32'h0042);

        // Halt beats jump; interrupt cannot wake; resume advances
        halt_cmd = 1; jump_taken = 1; jump_imm = 12'd5; cycle("halt"); idle();
        chk("h.pc", 32'(pc), 32'h0042);
        chk("h.halted", 32'(halted), 32'h1);
        clk_en = 0; int_enable_cmd = 1; cycle("h.ien"); idle();
        int_req = 1; ret_cmd = 1; jump_taken = 1; cycle("h.ign"); idle();
        chk("h.hold", 32'(pc), 32'h0042);
        int_disable_cmd = 1; int_enable_cmd = 1; resume = 1; cycle("resume"); idle();
        chk("r.pc", 32'(pc), 32'h0044);

        // Async reset between edges in the middle of a call
        jump(12'd40, 1);
        @(negedge clk); #2; reset = 1; #1;
        chk("ar.pc", 32'(pc), 32'h0);
        chk("ar.empty", 32'(stack_empty), 32'h1);
        m_reset(); sb.delete();
        @(negedge clk); reset = 0;
        cycle("ar.seq");

        // Random mix against the model
        for (int n = 0; n < 600; n++) begin
            clk_en          = ($urandom_range(3) != 0);
            halt_cmd        = ($urandom_range(39) == 0);
            resume          = ($urandom_range(3) == 0);
            int_req         = ($urandom_range(9) == 0);
            int_enable_cmd  = ($urandom_range(15) == 0);
            int_disable_cmd = ($urandom_range(31) == 0);
            ret_cmd         = ($urandom_range(7) == 0);
            jump_taken      = ($urandom_range(6) == 0);
            jump_link       = $urandom_range(1) == 1;
            jump_imm        = 12'($urandom);
            branch_taken    = ($urandom_range(4) == 0);
            branch_imm      = 6'($urandom);
            cycle("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
